// File: rtl/fpu_pkg.sv
// Shared FPU definitions: radix-4 Booth digit codes, multiplier FSM states and the digit encoder.
package fpu_pkg;

  typedef enum logic [2:0] {
    BOOTH_0  = 3'b000,
    BOOTH_P1 = 3'b001,
    BOOTH_P2 = 3'b010,
    BOOTH_N1 = 3'b111,
    BOOTH_N2 = 3'b110
  } booth_dig_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // Recode an overlapping 3-bit multiplier window into a signed radix-4 digit.
  function automatic booth_dig_e booth_enc(input logic [2:0] win);
    booth_dig_e dig;
    unique case (win)
      3'b001, 3'b010: dig = BOOTH_P1;
      3'b011:         dig = BOOTH_P2;
      3'b100:         dig = BOOTH_N2;
      3'b101, 3'b110: dig = BOOTH_N1;
      default:        dig = BOOTH_0;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Booth partial-product selector: magnitude {0,a,2a} plus a negate flag that feeds the adder carry-in.
module booth_r4_pp_sel
  import fpu_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  booth_dig_e   dig,
  output logic [W+1:0] pp_mag,
  output logic         pp_neg
);

  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    unique case (dig)
      BOOTH_P1: pp_mag = {2'b00, a};
      BOOTH_P2: pp_mag = {1'b0, a, 1'b0};
      BOOTH_N1: begin
        pp_mag = {2'b00, a};
        pp_neg = 1'b1;
      end
      BOOTH_N2: begin
        pp_mag = {1'b0, a, 1'b0};
        pp_neg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional BOOTH_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_r4_seq_mul
  import fpu_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);

  localparam int unsigned N_DIG = W / 2 + 1;
  localparam int unsigned AW    = W + 3;
  localparam int unsigned CW    = 2 * AW;
  localparam int unsigned CNT_W = $clog2(N_DIG);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mreg_q, mreg_d;
  logic [W-1:0]     a_q, a_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  booth_dig_e       dig;
  logic [W+1:0]     pp_mag;
  logic             pp_neg;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [CW-1:0]    shifted;

  assign dig = booth_enc(mreg_q[2:0]);

  booth_r4_pp_sel #(.W(W)) u_pp_sel (
    .a      (a_q),
    .dig    (dig),
    .pp_mag (pp_mag),
    .pp_neg (pp_neg)
  );

  // Negative digits add ~mag with a carry-in of one (two's complement).
  always_comb begin
    addend  = pp_neg ? ~{1'b0, pp_mag} : {1'b0, pp_mag};
    sum     = acc_q + addend + AW'(pp_neg);
    shifted = CW'($signed({sum, mreg_q}) >>> 2);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mreg_d      = mreg_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          acc_d   = '0;
          mreg_d  = {2'b00, b, 1'b0};
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        {acc_d, mreg_d} = shifted;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_DIG - 1)) begin
          state_d = ST_DONE;
        end
`ifdef BOOTH_MUL_EARLY_EXIT_EN
        else begin
          int  rem;
          int  skip;
          logic rest_zero;
          // Bits at or below rem are the multiplier bits still to be recoded (incl. overlap bit).
          rem       = int'(W) + 2 - 2 * (int'(cnt_q) + 1);
          skip      = int'(N_DIG) - 1 - int'(cnt_q);
          rest_zero = 1'b1;
          for (int i = 0; i < int'(AW); i++) begin
            if (i <= rem && shifted[i]) rest_zero = 1'b0;
          end
          if (rest_zero) begin
            {acc_d, mreg_d} = CW'($signed(shifted) >>> (2 * skip));
            state_d         = ST_DONE;
          end
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mreg_q      <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mreg_q      <= mreg_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // in_ready drops while rst is asserted and rises on the first cycle after it.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Final {acc,mreg} holds 2*a*b; dropping the guard bit leaves the product.
  assign prod      = {acc_q[W-3:0], mreg_q[AW-1:1]};

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul (W=24): directed corners plus randomized traffic vs a*b.
module tb_booth_r4_seq_mul;

  localparam int unsigned W      = 24;
  localparam int unsigned N_OPS  = 3000;
  localparam int unsigned LIMIT  = 90000;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 14;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  int          got;
  bit          drv_done;

  booth_r4_seq_mul #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Launch one operation, return after the result has been accepted.
  task automatic directed(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_vld"}, 64'(out_valid), 64'd1);
    if (exp_lat > 0) check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_prod"}, 64'(prod), ref_mul(aa, bb));
    @(posedge clk);
  endtask

  initial begin
    logic [2*W-1:0] held;
    int             n;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_prod", 64'(prod), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    directed(24'hFFFFFF, 24'hFFFFFF, 14, "max");
    check_eq("max_const", ref_mul(24'hFFFFFF, 24'hFFFFFF), 64'h0000FFFFFE000001);
    directed(24'h800000, 24'h800000, 0, "msb");
    directed(24'h000001, 24'hABCDEF, 0, "one");
    directed(24'h123456, 24'h000000, ZERO_LAT, "zero");

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    a = 24'h5A5A5A; b = 24'hC3C3C3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = prod;
    check_eq("bp_prod", 64'(held), ref_mul(24'h5A5A5A, 24'hC3C3C3));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_vld", 64'(out_valid), 64'd1);
      check_eq("bp_hold", 64'(prod), 64'(held));
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_rdy", 64'(in_ready), 64'd1);
    check_eq("bp_release_vld", 64'(out_valid), 64'd0);

    // Reset while digit 5 is in progress.
    a = 24'hFEDCBA; b = 24'h987654; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_rdy_in_rst", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_vld", 64'(out_valid), 64'd0);
    check_eq("abort_rdy", 64'(in_ready), 64'd1);
    directed(24'd3, 24'd5, 14, "after_abort");

    // Random traffic: driver and monitor run concurrently against a queue of a*b.
    got = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < int'(N_OPS) && cyc < int'(LIMIT); k++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          int           sel;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          sel = int'($urandom_range(0, 15));
          ra  = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
          rb  = (sel == 2) ? '0 : (sel == 3) ? '1 : (sel == 4) ? W'($urandom_range(0, 255)) : W'($urandom);
          @(negedge clk);
          a = ra; b = rb; in_valid = 1'b1;
          while (!in_ready && cyc < int'(LIMIT)) @(negedge clk);
          exp_q.push_back(ref_mul(ra, rb));
          @(posedge clk);
          @(negedge clk);
          in_valid = 1'b0;
          a = W'($urandom); b = W'($urandom);
        end
        drv_done = 1'b1;
      end
      begin
        while (got < int'(N_OPS) && cyc < int'(LIMIT)) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check_eq("rand_dup", 64'(prod), 64'hDEAD);
            end else begin
              check_eq("rand_prod", 64'(prod), exp_q.pop_front());
            end
            got++;
          end
        end
      end
    join
    check_eq("rand_count", 64'(got), 64'(N_OPS));
    check_eq("rand_driver_done", 64'(drv_done), 64'd1);
    repeat (20) @(negedge clk);
    check_eq("rand_leftover", 64'(exp_q.size()), 64'd0);
    check_eq("rand_no_extra", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
